// File: rtl/game_pkg.sv
// Shared game-flow types and constants for the sequencer, background scroller and colour mapper.
package game_pkg;

  localparam int unsigned COIN_NUM      = 3;
  localparam int unsigned FRAME_CNT_MAX = 3095;
  localparam int unsigned FC_W          = $clog2(FRAME_CNT_MAX + 1);
  localparam int unsigned PIT_HEIGHT    = 479;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DYING = 3'd3,
    ST_OVER  = 3'd4
  } game_state_t;

  // Number of set bits in a coin vector; 2 bits covers up to three coins.
  function automatic logic [1:0] coin_count(input logic [COIN_NUM-1:0] v);
    logic [1:0] n;
    n = '0;
    for (int i = 0; i < COIN_NUM; i++) begin
      n = n + 2'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/game_sequencer_edge_detect.sv
// Registered 1-bit rising-edge detector: o_rise is high for one clock, one clock after the edge.
module edge_detect (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;
  logic r_rise;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_prev <= i_sig;
      r_rise <= i_sig & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: idle/run/pause/dying/over sequencing, coin status, score and lives.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned DEATH_Y      = 470,
  parameter int unsigned DEATH_FRAMES = 60,
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned SCORE_MAX    = 255
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_frame_clk,
  input  logic                i_start_key,
  input  logic                i_pause_key,
  input  logic [FC_W-1:0]     i_frame_counter,
  input  logic [9:0]          i_ground_y,
  input  logic [9:0]          i_stick_foot_y,
  input  logic [COIN_NUM-1:0] i_coin_hit,
  output logic                o_restart,
  output logic                o_scroll_en,
  output logic [COIN_NUM-1:0] o_coin_status,
  output logic [2:0]          o_game_state,
  output logic [7:0]          o_score,
  output logic [1:0]          o_lives
);

  logic w_fr_tick;
  logic w_start_edge;
  logic w_pause_edge;

  edge_detect u_frame_edge (.i_clk(i_clk), .i_reset_n(i_reset_n), .i_sig(i_frame_clk),
                            .o_rise(w_fr_tick));
  edge_detect u_start_edge (.i_clk(i_clk), .i_reset_n(i_reset_n), .i_sig(i_start_key),
                            .o_rise(w_start_edge));
  edge_detect u_pause_edge (.i_clk(i_clk), .i_reset_n(i_reset_n), .i_sig(i_pause_key),
                            .o_rise(w_pause_edge));

  game_state_t         r_state;
  logic                r_restart;
  logic                r_scroll_en;
  logic [COIN_NUM-1:0] r_coin;
  logic [7:0]          r_score;
  logic [1:0]          r_lives;
  logic [7:0]          r_death_cnt;
  logic                r_start_pend;
  logic                r_pause_pend;
  logic [FC_W-1:0]     r_fc_prev;

  logic                w_start;
  logic                w_pause;
  logic                w_pit_death;
  logic                w_wrap;
  logic                w_state_ok;
  logic [COIN_NUM-1:0] w_hits;
  logic [8:0]          w_score_sum;
  logic [7:0]          w_score_next;
  logic [1:0]          w_lives_dec;

  // Key requests include an edge arriving in the same cycle as the frame tick.
  assign w_start      = r_start_pend | w_start_edge;
  assign w_pause      = r_pause_pend | w_pause_edge;
  assign w_pit_death  = (i_ground_y == 10'(PIT_HEIGHT)) && (i_stick_foot_y >= 10'(DEATH_Y));
  assign w_wrap       = i_frame_counter < r_fc_prev;
  assign w_state_ok   = r_state <= ST_OVER;
  assign w_hits       = i_coin_hit & r_coin;
  assign w_score_sum  = {1'b0, r_score} + {7'd0, coin_count(w_hits)};
  assign w_score_next = (w_score_sum > 9'(SCORE_MAX)) ? 8'(SCORE_MAX) : w_score_sum[7:0];
  assign w_lives_dec  = r_lives - 2'd1;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_restart    <= 1'b0;
      r_scroll_en  <= 1'b0;
      r_coin       <= '1;
      r_score      <= '0;
      r_lives      <= 2'(START_LIVES);
      r_death_cnt  <= '0;
      r_start_pend <= 1'b0;
      r_pause_pend <= 1'b0;
      r_fc_prev    <= '0;
    end else begin
      r_restart <= 1'b0;
      r_fc_prev <= i_frame_counter;

      if (w_fr_tick) begin
        r_start_pend <= 1'b0;
        r_pause_pend <= 1'b0;
      end else begin
        r_start_pend <= w_start;
        r_pause_pend <= w_pause;
      end

      if (r_state == ST_RUN) begin
        r_coin  <= r_coin & ~i_coin_hit;
        r_score <= w_score_next;
      end
      // Lap reload overrides any coin cleared in the same cycle.
      if (w_wrap) begin
        r_coin <= '1;
      end

      if (!w_state_ok) begin
        r_state     <= ST_IDLE;
        r_scroll_en <= 1'b0;
      end else if (w_fr_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (w_start) begin
              r_state     <= ST_RUN;
              r_restart   <= 1'b1;
              r_scroll_en <= 1'b1;
              r_score     <= '0;
              r_lives     <= 2'(START_LIVES);
              r_coin      <= '1;
            end
          end
          ST_RUN: begin
            if (w_pause) begin
              r_state     <= ST_PAUSE;
              r_scroll_en <= 1'b0;
            end else if (w_pit_death) begin
              r_state     <= ST_DYING;
              r_scroll_en <= 1'b0;
              r_death_cnt <= '0;
            end
          end
          ST_PAUSE: begin
            if (w_start || w_pause) begin
              r_state     <= ST_RUN;
              r_scroll_en <= 1'b1;
            end
          end
          ST_DYING: begin
            if (r_death_cnt == 8'(DEATH_FRAMES - 1)) begin
              r_lives     <= w_lives_dec;
              r_death_cnt <= '0;
              if (w_lives_dec == 2'd0) begin
                r_state     <= ST_OVER;
                r_scroll_en <= 1'b0;
              end else begin
                r_state     <= ST_RUN;
                r_restart   <= 1'b1;
                r_scroll_en <= 1'b1;
                r_coin      <= '1;
              end
            end else begin
              r_death_cnt <= r_death_cnt + 8'd1;
            end
          end
          ST_OVER: begin
            if (w_start) begin
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state     <= ST_IDLE;
            r_scroll_en <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_restart     = r_restart;
  assign o_scroll_en   = r_scroll_en;
  assign o_coin_status = r_coin;
  assign o_game_state  = r_state;
  assign o_score       = r_score;
  assign o_lives       = r_lives;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: per-cycle model comparison plus directed literal checks.
module tb_game_sequencer;

  logic        clk;
  logic        reset_n;
  logic        frame_clk;
  logic        start_key;
  logic        pause_key;
  logic [11:0] frame_counter;
  logic [9:0]  ground_y;
  logic [9:0]  foot_y;
  logic [2:0]  coin_hit;
  logic        restart;
  logic        scroll_en;
  logic [2:0]  coin_status;
  logic [2:0]  game_state;
  logic [7:0]  score;
  logic [1:0]  lives;

  game_sequencer dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_frame_clk    (frame_clk),
    .i_start_key    (start_key),
    .i_pause_key    (pause_key),
    .i_frame_counter(frame_counter),
    .i_ground_y     (ground_y),
    .i_stick_foot_y (foot_y),
    .i_coin_hit     (coin_hit),
    .o_restart      (restart),
    .o_scroll_en    (scroll_en),
    .o_coin_status  (coin_status),
    .o_game_state   (game_state),
    .o_score        (score),
    .o_lives        (lives)
  );

  int n_checks  = 0;
  int n_pass    = 0;
  int n_restart = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame strobe: one rising edge every 10 clocks.
  initial begin
    frame_clk = 1'b0;
    forever begin
      repeat (5) @(posedge clk);
      #1 frame_clk = ~frame_clk;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- behavioural model (input history based) ----------------
  int       m_state, m_score, m_lives, m_ticks_dying, m_fc_prev;
  bit [2:0] m_coins;
  bit       m_restart, m_valid;
  bit       m_spend, m_ppend;
  bit       fc1, fc2, s1, s2, p1, p2;
  bit       t_tick, t_se, t_pe, t_start, t_pause;

  initial begin
    m_valid = 0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_state = 0; m_restart = 0; m_coins = 3'b111; m_score = 0; m_lives = 3;
        m_ticks_dying = 0; m_spend = 0; m_ppend = 0; m_fc_prev = 0;
        fc1 = 0; fc2 = 0; s1 = 0; s2 = 0; p1 = 0; p2 = 0;
        m_valid = 1;
      end else begin
        t_tick  = fc1 && !fc2;
        t_se    = s1 && !s2;
        t_pe    = p1 && !p2;
        t_start = m_spend || t_se;
        t_pause = m_ppend || t_pe;
        if (t_tick) begin
          m_spend = 0; m_ppend = 0;
        end else begin
          m_spend = t_start; m_ppend = t_pause;
        end
        m_restart = 0;
        if (m_state == 1) begin
          m_score = m_score + $countones(coin_hit & m_coins);
          if (m_score > 255) m_score = 255;
          m_coins = m_coins & ~coin_hit;
        end
        if (int'(frame_counter) < m_fc_prev) m_coins = 3'b111;
        m_fc_prev = int'(frame_counter);
        if (t_tick) begin
          case (m_state)
            0: if (t_start) begin
                 m_state = 1; m_restart = 1; m_score = 0; m_lives = 3; m_coins = 3'b111;
               end
            1: if (t_pause) m_state = 2;
               else if (ground_y == 10'd479 && foot_y >= 10'd470) begin
                 m_state = 3; m_ticks_dying = 0;
               end
            2: if (t_start || t_pause) m_state = 1;
            3: begin
                 m_ticks_dying++;
                 if (m_ticks_dying == 60) begin
                   m_lives--;
                   if (m_lives == 0) m_state = 4;
                   else begin
                     m_state = 1; m_restart = 1; m_coins = 3'b111;
                   end
                 end
               end
            4: if (t_start) m_state = 0;
            default: m_state = 0;
          endcase
        end
        fc2 = fc1; fc1 = frame_clk;
        s2 = s1;   s1 = start_key;
        p2 = p1;   p1 = pause_key;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (o_restart_seen()) n_restart++;
      if (m_valid) begin
        n_checks++;
        if (int'(game_state) == m_state && scroll_en === (m_state == 1) &&
            restart === m_restart && coin_status === m_coins &&
            int'(score) == m_score && int'(lives) == m_lives) begin
          n_pass++;
        end else begin
          $display("FAIL cycle_model t=%0t: dut st=%0d se=%0b rs=%0b coin=%b sc=%0d lv=%0d, model st=%0d se=%0b rs=%0b coin=%b sc=%0d lv=%0d",
                   $time, game_state, scroll_en, restart, coin_status, score, lives,
                   m_state, (m_state == 1), m_restart, m_coins, m_score, m_lives);
        end
      end
    end
  end

  function automatic bit o_restart_seen();
    return restart === 1'b1;
  endfunction

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    step(1); start_key = 1'b1;
    step(2); start_key = 1'b0;
  endtask

  task automatic press_pause();
    step(1); pause_key = 1'b1;
    step(2); pause_key = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (int'(game_state) != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(game_state), s);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},   int'(game_state),  0);
    check({tag, "_scroll"},  int'(scroll_en),   0);
    check({tag, "_restart"}, int'(restart),     0);
    check({tag, "_coins"},   int'(coin_status), 7);
    check({tag, "_score"},   int'(score),       0);
    check({tag, "_lives"},   int'(lives),       3);
  endtask

  initial begin
    reset_n = 1'b0; start_key = 1'b0; pause_key = 1'b0; frame_counter = 12'd100;
    ground_y = 10'd0; foot_y = 10'd0; coin_hit = 3'b000;
    step(3);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset");

    press_start();
    wait_state(1, 40, "start_run");
    check("start_restart", int'(restart), 1);
    check("start_scroll", int'(scroll_en), 1);
    check("start_lives", int'(lives), 3);
    check("start_coins", int'(coin_status), 7);
    step(3);
    check("restart_count_start", n_restart, 1);

    // Lap wrap with a coin hit in the same cycle: reload wins, score still counts.
    step(1); frame_counter = 12'd3094;
    step(1); frame_counter = 12'd0; coin_hit = 3'b001;
    step(1); frame_counter = 12'd1; coin_hit = 3'b000;
    @(negedge clk);
    check("wrap_coins", int'(coin_status), 7);
    check("wrap_score", int'(score), 1);

    coin_hit = 3'b101; step(5); coin_hit = 3'b000;
    @(negedge clk);
    check("hit101_coins", int'(coin_status), 2);
    check("hit101_score", int'(score), 3);
    coin_hit = 3'b111; step(1); coin_hit = 3'b000;
    @(negedge clk);
    check("hit111_coins", int'(coin_status), 0);
    check("hit111_score", int'(score), 4);

    press_pause();
    wait_state(2, 40, "pause");
    check("pause_scroll", int'(scroll_en), 0);
    press_start();
    wait_state(1, 40, "resume");
    step(3);
    check("restart_count_resume", n_restart, 1);

    // Pit boundary: foot at 469 survives, 470 dies.
    ground_y = 10'd479; foot_y = 10'd469;
    step(40);
    check("foot469_alive", int'(game_state), 1);
    foot_y = 10'd470;
    wait_state(3, 30, "die1_enter");
    check("dying_scroll", int'(scroll_en), 0);
    foot_y = 10'd472;
    wait_state(1, 700, "respawn1");
    check("respawn1_restart", int'(restart), 1);
    check("respawn1_lives", int'(lives), 2);
    check("respawn1_score", int'(score), 4);
    check("respawn1_coins", int'(coin_status), 7);
    step(3);
    check("restart_count_respawn1", n_restart, 2);

    wait_state(3, 30, "die2_enter");
    wait_state(1, 700, "respawn2");
    check("respawn2_lives", int'(lives), 1);
    wait_state(3, 30, "die3_enter");
    wait_state(4, 700, "game_over");
    check("over_lives", int'(lives), 0);
    check("over_scroll", int'(scroll_en), 0);
    step(3);
    check("restart_count_over", n_restart, 3);

    ground_y = 10'd0;
    press_start();
    wait_state(0, 40, "over_to_idle");
    step(15);
    check("idle_holds", int'(game_state), 0);
    press_start();
    wait_state(1, 40, "new_game");
    check("new_game_lives", int'(lives), 3);
    check("new_game_score", int'(score), 0);
    step(3);
    check("restart_count_new_game", n_restart, 4);

    // 85 laps of three coins each reach exactly 255.
    for (int i = 0; i < 85; i++) begin
      step(1); frame_counter = 12'd3094; coin_hit = 3'b000;
      step(1); frame_counter = 12'd0;    coin_hit = 3'b111;
    end
    step(1); coin_hit = 3'b000;
    @(negedge clk);
    check("sat_score", int'(score), 255);
    check("sat_coins", int'(coin_status), 7);
    coin_hit = 3'b001; step(1); coin_hit = 3'b000;
    @(negedge clk);
    check("sat_hold_score", int'(score), 255);
    check("sat_hold_coins", int'(coin_status), 6);

    ground_y = 10'd479; foot_y = 10'd472;
    wait_state(3, 30, "die_before_reset");
    step(20);
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset_dying");
    step(3);
    check("restart_count_reset", n_restart, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-flow controller for the scrolling-terrain datapath.
- Sequences the background scroller through idle, run, pause, dying and game-over states.
- Owns the 3-bit CoinStatus vector that the background and coin-collision logic consume. Owns score and lives.
- Issues the restart pulse and the scroll enable that gate frame_counter advance. Sits between keyboard decode, game_logic collision outputs and the background block.

Parameters:
- FRAME_CNT_MAX, 3095, last frame_counter value before wrap (matches the background scroller).
- PIT_HEIGHT, 479, GroundY value that identifies a pitfall column.
- DEATH_Y, 470, stickman foot Y at or beyond which the stickman is dead while over a pit.
- DEATH_FRAMES, 60, frames spent in DYING before respawn or game over.
- START_LIVES, 3, lives loaded at new game.
- SCORE_MAX, 255, score saturation value.

Ports:
- Clk  in  1  50 MHz system clock
- Reset_n  in  1  synchronous, active-low reset
- frame_clk  in  1  ~60 Hz frame strobe; rising edge detected internally
- start_key  in  1  level; start or resume request
- pause_key  in  1  level; pause request
- frame_counter  in  12  current scroll position from background
- GroundY  in  10  terrain height under the stickman
- StickFootY  in  10  stickman bottom Y
- coin_hit  in  3  per-coin collision, level, from game_logic
- restart  out  1  one-Clk pulse; resets background frame_counter
- scroll_en  out  1  high only in RUN; background advances only when set
- CoinStatus  out  3  1 = coin present
- game_state  out  3  encoded state, for the colour mapper and HUD
- score  out  8  collected coin count, saturating
- lives  out  2  remaining lives

Behaviour:
- Reset (Reset_n low at a Clk edge): state IDLE, restart 0, scroll_en 0, CoinStatus 3'b111, score 0, lives START_LIVES, edge/key history registers cleared.
- Frame tick: fr_tick = frame_clk high this Clk and low on the previous Clk (registered, so one Clk latency). All state transitions except restart generation occur on fr_tick.
- Key edges: start_key and pause_key are rising-edge detected per Clk. Edges are latched as pending until the next fr_tick, then consumed.
- States:
  - IDLE (0): on pending start → RUN. Assert restart for the Clk following the transition. Load score 0, lives START_LIVES, CoinStatus 111.
  - RUN (1): scroll_en 1.
    - Pending pause → PAUSE.
    - Else if GroundY == PIT_HEIGHT and StickFootY >= DEATH_Y → DYING, and clear the death-frame counter.
  - PAUSE (2): scroll_en 0. Pending start or pause → RUN. No restart pulse; frame_counter is held.
  - DYING (3): scroll_en 0. Counts fr_ticks; at count DEATH_FRAMES-1, lives decrements.
    - If the new lives value is 0 → OVER.
    - Else → RUN, with a restart pulse and CoinStatus reloaded to 111; score is retained.
  - OVER (4): scroll_en 0. Pending start → IDLE. The transition IDLE→RUN then requires a second start edge.
  - Encodings 5–7 are illegal and recover to IDLE on the next Clk.
- Coins: evaluated every Clk, but only in RUN.
  - For each bit with coin_hit[i] and CoinStatus[i] both 1: clear CoinStatus[i] and add 1 to score.
  - Simultaneous hits add the popcount (0–3) in one cycle. Score saturates at SCORE_MAX.
  - A hit on an already-cleared coin has no effect.
- Lap wrap: when frame_counter is lower than its registered previous value (wrap from FRAME_CNT_MAX), CoinStatus reloads to 111 on the next Clk. If a hit occurs in the same cycle, the reload wins.
- restart: exactly one Clk wide, registered output, asserted the Clk after the transitioning fr_tick. Never asserted on PAUSE→RUN.
- Reset mid-DYING or mid-pause returns all outputs to reset values; no restart pulse is emitted.
- Width rules:
  - score add uses a 9-bit intermediate, then clamps.
  - lives decrement never underflows: at 0 the block is in OVER.
  - The death counter is 8 bits; DEATH_FRAMES must not exceed 256.

Decomposition:
- Package game_pkg:
  - game_state_t enum {ST_IDLE, ST_RUN, ST_PAUSE, ST_DYING, ST_OVER}.
  - Constants COIN_NUM=3, PIT_HEIGHT, FRAME_CNT_MAX, shared with background and color_mapper.
- One sub-module: edge_detect (1-bit rising-edge detector, registered). Instantiated for frame_clk, start_key and pause_key.

Test Plan:
- Reset then one start edge at a fr_tick → game_state 1, restart high for exactly 1 Clk, scroll_en 1, lives 3, score 0, CoinStatus 111.
- In RUN, coin_hit=3'b101 held for 5 Clk → CoinStatus 010, score 2 (not 10). Then coin_hit=3'b111 → CoinStatus 000, score 3.
- In RUN, GroundY=479 and StickFootY=472 → DYING at next fr_tick, scroll_en 0. After 60 fr_ticks: lives 2, RUN, restart pulse, CoinStatus 111, score unchanged.
- Three consecutive deaths → lives 0, state OVER, no restart pulse. Start edge → IDLE; second start edge → RUN with lives 3.
- Pause edge in RUN → PAUSE with scroll_en 0 and no restart. Start edge → RUN, restart stays 0.
- frame_counter steps 3094→0 with coin_hit=3'b001 in the same cycle → CoinStatus 111, score +1. Score at 255 plus a hit → stays 255.
